// File: rtl/dat_chunk_encoder.sv
// Dense-to-sparse chunk encoder: per beat emits the nonzero map and the packed nonzero bytes
// through a two-stage pipeline, and reports chunk completion with the chunk's nonzero count.
module dat_chunk_encoder #(
    parameter int unsigned PARAM_BUS_SIZE = 128,
    parameter int unsigned PARAM_MEM_SIZE = 512
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic                                              start_i,
    input  logic                                              dense_valid_i,
    input  logic [PARAM_BUS_SIZE-1:0][7:0]                    dense_data_i,
    output logic                                              dense_ready_o,
    output logic [PARAM_BUS_SIZE-1:0]                         wr_sparsemap_o,
    output logic [PARAM_BUS_SIZE-1:0][7:0]                    wr_nonzero_data_o,
    output logic                                              wr_valid_o,
    output logic [$clog2(PARAM_MEM_SIZE/PARAM_BUS_SIZE)-1:0]  wr_count_o,
    output logic                                              busy_o,
    output logic                                              chunk_done_o,
    output logic [$clog2(PARAM_MEM_SIZE+1)-1:0]               chunk_nnz_o
);

    localparam int unsigned PARAM_WR_DAT_CYC_NUM = PARAM_MEM_SIZE / PARAM_BUS_SIZE;
    localparam int unsigned CntW  = $clog2(PARAM_WR_DAT_CYC_NUM);
    localparam int unsigned NnzW  = $clog2(PARAM_MEM_SIZE + 1);
    localparam int unsigned PopW  = $clog2(PARAM_BUS_SIZE + 1);
    localparam int unsigned SlotW = $clog2(PARAM_BUS_SIZE);

    typedef enum logic [1:0] {StIdle, StFill, StDrain, StDone} state_e;

    state_e                          state_q, state_d;
    logic [CntW-1:0]                 cnt_q, cnt_d;
    logic [NnzW-1:0]                 nnz_q, nnz_d;
    logic [NnzW-1:0]                 chunk_nnz_q, chunk_nnz_d;

    logic                            s1_valid_q, s1_valid_d;
    logic [PARAM_BUS_SIZE-1:0][7:0]  s1_data_q, s1_data_d;
    logic [PARAM_BUS_SIZE-1:0]       s1_map_q, s1_map_d;
    logic [CntW-1:0]                 s1_idx_q, s1_idx_d;

    logic                            wr_valid_q, wr_valid_d;
    logic [PARAM_BUS_SIZE-1:0]       wr_map_q, wr_map_d;
    logic [PARAM_BUS_SIZE-1:0][7:0]  wr_data_q, wr_data_d;
    logic [CntW-1:0]                 wr_count_q, wr_count_d;

    logic                            accept;
    logic [PARAM_BUS_SIZE-1:0]       dense_map;
    logic [PARAM_BUS_SIZE-1:0][7:0]  packed_data;
    logic [PopW-1:0]                 pop;

    assign accept = (state_q == StFill) && dense_valid_i;

    always_comb begin
        dense_map = '0;
        for (int j = 0; j < PARAM_BUS_SIZE; j++) begin
            dense_map[j] = (dense_data_i[j] != 8'h00);
        end
    end

    // Slot k receives the (k+1)-th nonzero byte; the running slot index doubles as popcount.
    always_comb begin
        packed_data = '0;
        pop         = '0;
        for (int j = 0; j < PARAM_BUS_SIZE; j++) begin
            if (s1_map_q[j]) begin
                packed_data[pop[SlotW-1:0]] = s1_data_q[j];
                pop = pop + PopW'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nnz_d       = nnz_q;
        chunk_nnz_d = chunk_nnz_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFill;
                    cnt_d   = '0;
                    nnz_d   = '0;
                end
            end
            StFill: begin
                if (accept) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(PARAM_WR_DAT_CYC_NUM - 1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // S1 empty means the final strobe is on the output now; done follows it.
                if (!s1_valid_q) begin
                    state_d     = StDone;
                    chunk_nnz_d = nnz_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (s1_valid_q) begin
            nnz_d = nnz_d + NnzW'(pop);
        end
    end

    always_comb begin
        s1_valid_d = accept;
        s1_data_d  = s1_data_q;
        s1_map_d   = s1_map_q;
        s1_idx_d   = s1_idx_q;
        if (accept) begin
            s1_data_d = dense_data_i;
            s1_map_d  = dense_map;
            s1_idx_d  = cnt_q;
        end

        wr_valid_d = s1_valid_q;
        wr_map_d   = wr_map_q;
        wr_data_d  = wr_data_q;
        wr_count_d = wr_count_q;
        if (s1_valid_q) begin
            wr_map_d   = s1_map_q;
            wr_data_d  = packed_data;
            wr_count_d = s1_idx_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            nnz_q       <= '0;
            chunk_nnz_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_map_q    <= '0;
            s1_idx_q    <= '0;
            wr_valid_q  <= 1'b0;
            wr_map_q    <= '0;
            wr_data_q   <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nnz_q       <= nnz_d;
            chunk_nnz_q <= chunk_nnz_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_map_q    <= s1_map_d;
            s1_idx_q    <= s1_idx_d;
            wr_valid_q  <= wr_valid_d;
            wr_map_q    <= wr_map_d;
            wr_data_q   <= wr_data_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign dense_ready_o     = (state_q == StFill);
    assign busy_o            = (state_q != StIdle);
    assign chunk_done_o      = (state_q == StDone);
    assign chunk_nnz_o       = chunk_nnz_q;
    assign wr_valid_o        = wr_valid_q;
    assign wr_sparsemap_o    = wr_map_q;
    assign wr_nonzero_data_o = wr_data_q;
    assign wr_count_o        = wr_count_q;

endmodule

// File: tb/tb_dat_chunk_encoder.sv
// Directed bench for dat_chunk_encoder: beat tables with hand-derived map/packed/nnz values,
// plus sequences for idle, gaps, ignored start pulses and mid-chunk reset.
module tb_dat_chunk_encoder;

    localparam int unsigned BUS = 128;
    localparam int unsigned MEM = 512;
    localparam int unsigned NB  = MEM / BUS;

    typedef struct {
        logic [BUS-1:0][7:0] din;
        logic [BUS-1:0]      map;
        logic [BUS-1:0][7:0] pk;
        int                  pop;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic                 start_i;
    logic                 dense_valid_i;
    logic [BUS-1:0][7:0]  dense_data_i;
    logic                 dense_ready_o;
    logic [BUS-1:0]       wr_sparsemap_o;
    logic [BUS-1:0][7:0]  wr_nonzero_data_o;
    logic                 wr_valid_o;
    logic [1:0]           wr_count_o;
    logic                 busy_o;
    logic                 chunk_done_o;
    logic [9:0]           chunk_nnz_o;

    beat_t vecs[NB];
    int    exp_total;
    int    n_vec  = 0;
    int    n_fail = 0;

    dat_chunk_encoder #(
        .PARAM_BUS_SIZE(BUS),
        .PARAM_MEM_SIZE(MEM)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .dense_valid_i    (dense_valid_i),
        .dense_data_i     (dense_data_i),
        .dense_ready_o    (dense_ready_o),
        .wr_sparsemap_o   (wr_sparsemap_o),
        .wr_nonzero_data_o(wr_nonzero_data_o),
        .wr_valid_o       (wr_valid_o),
        .wr_count_o       (wr_count_o),
        .busy_o           (busy_o),
        .chunk_done_o     (chunk_done_o),
        .chunk_nnz_o      (chunk_nnz_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic beat_t mk_dense();
        beat_t b;
        for (int j = 0; j < BUS; j++) b.din[j] = 8'(j + 1);
        b.map = '1;
        b.pk  = b.din;
        b.pop = BUS;
        return b;
    endfunction

    function automatic beat_t mk_sparse();
        beat_t b;
        b.din      = '0;
        b.din[5]   = 8'hAA;
        b.din[17]  = 8'h11;
        b.din[127] = 8'hFF;
        b.map      = '0;
        b.map[5]   = 1'b1;
        b.map[17]  = 1'b1;
        b.map[127] = 1'b1;
        b.pk       = '0;
        b.pk[0]    = 8'hAA;
        b.pk[1]    = 8'h11;
        b.pk[2]    = 8'hFF;
        b.pop      = 3;
        return b;
    endfunction

    function automatic beat_t mk_zero();
        beat_t b;
        b.din = '0;
        b.map = '0;
        b.pk  = '0;
        b.pop = 0;
        return b;
    endfunction

    // Odd bytes 8'h5A, even bytes zero: 64 nonzeros packed into slots 0..63.
    function automatic beat_t mk_odd();
        beat_t b;
        b.din = '0;
        b.map = '0;
        b.pk  = '0;
        for (int j = 0; j < BUS; j++) begin
            if (j % 2 == 1) begin
                b.din[j] = 8'h5A;
                b.map[j] = 1'b1;
            end
        end
        for (int k = 0; k < 64; k++) b.pk[k] = 8'h5A;
        b.pop = 64;
        return b;
    endfunction

    task automatic check_strobe(input int idx);
        chk("wr_count", 512'(wr_count_o), 512'(idx));
        chk("wr_map", 512'(wr_sparsemap_o), 512'(vecs[idx].map));
        chk("wr_data_lo", 512'(wr_nonzero_data_o[63:0]), 512'(vecs[idx].pk[63:0]));
        chk("wr_data_hi", 512'(wr_nonzero_data_o[127:64]), 512'(vecs[idx].pk[127:64]));
    endtask

    // Runs one chunk from IDLE using vecs[]; checks ready, strobes, latency, done and nnz.
    task automatic run_chunk(input bit gappy, input bit poke);
        bit acc_e[64];
        int acc_cnt   = 0;
        int strobes   = 0;
        int last_acc  = -10;
        bit done_seen = 0;
        start_i       = 1'b1;
        dense_valid_i = 1'b0;
        step();
        start_i = 1'b0;
        chk("busy_after_start", 512'(busy_o), 512'(1));
        for (int c = 0; c < 60 && !done_seen; c++) begin
            bit v;
            bit exp_rdy;
            v             = gappy ? (c % 3 == 0) : 1'b1;
            exp_rdy       = (acc_cnt < NB);
            dense_valid_i = v;
            dense_data_i  = (acc_cnt < NB) ? vecs[acc_cnt].din : {BUS{8'h77}};
            start_i       = poke;
            chk("dense_ready", 512'(dense_ready_o), 512'(exp_rdy));
            acc_e[c] = v && exp_rdy;
            if (acc_e[c]) begin
                acc_cnt++;
                if (acc_cnt == NB) last_acc = c;
            end
            step();
            if (c >= 1 && acc_e[c-1]) begin
                chk("wr_valid", 512'(wr_valid_o), 512'(1));
                if (strobes < NB) check_strobe(strobes);
                strobes++;
            end else begin
                chk("wr_valid_idle", 512'(wr_valid_o), 512'(0));
            end
            chk("chunk_done", 512'(chunk_done_o), 512'(c == last_acc + 2));
            if (c == last_acc + 2) begin
                chk("chunk_nnz", 512'(chunk_nnz_o), 512'(exp_total));
                done_seen = 1;
            end
        end
        if (!done_seen) chk("chunk_done_timeout", 512'(0), 512'(1));
        dense_valid_i = 1'b0;
        step();
        start_i = 1'b0;
        chk("idle_after_done", 512'(busy_o), 512'(0));
        chk("done_one_cycle", 512'(chunk_done_o), 512'(0));
        chk("nnz_held", 512'(chunk_nnz_o), 512'(exp_total));
        chk("strobe_total", 512'(strobes), 512'(NB));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 512'(dense_ready_o), 512'(0));
        chk({tag, "_valid"}, 512'(wr_valid_o), 512'(0));
        chk({tag, "_map"}, 512'(wr_sparsemap_o), 512'(0));
        chk({tag, "_data_lo"}, 512'(wr_nonzero_data_o[63:0]), 512'(0));
        chk({tag, "_data_hi"}, 512'(wr_nonzero_data_o[127:64]), 512'(0));
        chk({tag, "_count"}, 512'(wr_count_o), 512'(0));
        chk({tag, "_busy"}, 512'(busy_o), 512'(0));
        chk({tag, "_done"}, 512'(chunk_done_o), 512'(0));
        chk({tag, "_nnz"}, 512'(chunk_nnz_o), 512'(0));
    endtask

    task automatic load_mixed();
        vecs[0]   = mk_dense();
        vecs[1]   = mk_sparse();
        vecs[2]   = mk_zero();
        vecs[3]   = mk_odd();
        exp_total = 128 + 3 + 0 + 64;
    endtask

    initial begin
        rst_i         = 1'b1;
        start_i       = 1'b0;
        dense_valid_i = 1'b0;
        dense_data_i  = '0;
        step();
        step();
        rst_i = 1'b0;
        check_all_zero("reset");

        // Valid without start must not be accepted.
        dense_valid_i = 1'b1;
        dense_data_i  = {BUS{8'h33}};
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_ready", 512'(dense_ready_o), 512'(0));
            chk("idle_wr_valid", 512'(wr_valid_o), 512'(0));
        end
        dense_valid_i = 1'b0;

        for (int i = 0; i < NB; i++) vecs[i] = mk_dense();
        exp_total = MEM;
        run_chunk(1'b0, 1'b0);

        load_mixed();
        run_chunk(1'b0, 1'b1);

        for (int i = 0; i < NB; i++) vecs[i] = mk_zero();
        exp_total = 0;
        run_chunk(1'b1, 1'b0);

        // Mid-chunk reset after two accepted beats.
        load_mixed();
        exp_total = 512;
        for (int i = 0; i < NB; i++) vecs[i] = mk_dense();
        run_chunk(1'b0, 1'b0);
        load_mixed();
        start_i = 1'b1;
        step();
        start_i       = 1'b0;
        dense_valid_i = 1'b1;
        dense_data_i  = vecs[0].din;
        step();
        dense_data_i = vecs[1].din;
        step();
        chk("pre_reset_strobe", 512'(wr_valid_o), 512'(1));
        dense_valid_i = 1'b0;
        rst_i         = 1'b1;
        step();
        rst_i = 1'b0;
        check_all_zero("midreset");
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_reset_valid", 512'(wr_valid_o), 512'(0));
            chk("post_reset_done", 512'(chunk_done_o), 512'(0));
        end
        run_chunk(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
